fbs_restore_ctrl: RTL and testbench
===================================

Name: fbs_restore_ctrl

Overview:
- Consumer end of the f-register backup system: on a return event it requests a restore from the backup stack and captures the 256-bit frame.
- It then writes the frame back into the f-register file one register per cycle.
- It sits between the control unit (start/busy) and the register-file write port, and stalls the pipeline until write-back completes.
- Protects against restore from an empty backup stack.

Parameters:
- NUM_REGS, 16, number of f registers in one frame.
- REG_WIDTH, 16, bits per register; frame width = NUM_REGS*REG_WIDTH (256).
- SKIP_MASK, 16'h0000, bit i set = register i is not written back (e.g. a return-value register); the cycle is still consumed.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle restore request from control unit.
- fcc  in  16  current backup-stack depth from the backup stack.
- restoreOut  in  1  backup stack frame-valid indication.
- frameIn  in  NUM_REGS*REG_WIDTH  frame from the backup stack dataOut.
- fbsRestore  out  1  restore request to the backup stack.
- regWrite  out  1  register-file write enable.
- regNum  out  4  register-file write address.
- regData  out  REG_WIDTH  register-file write data.
- busy  out  1  pipeline stall; high from the cycle after start until done.
- done  out  1  one-cycle pulse when write-back completes.
- underflow  out  1  one-cycle pulse when start arrives with fcc==0.

Behaviour:
- Reset: all outputs 0, state IDLE, index counter 0, frame register 0.
- Reset mid-operation returns to IDLE immediately. No further writes occur, and fbsRestore drops asynchronously.
- States: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE, start=1 and fcc!=0: go to REQ. busy=1 from the next cycle.
- IDLE, start=1 and fcc==0: underflow=1 for exactly one cycle and stay in IDLE. fbsRestore is never asserted and busy stays 0.
- REQ: fbsRestore=1 for exactly one cycle, then go to WAIT.
- WAIT: hold fbsRestore=0. In the first cycle with restoreOut=1, latch frameIn into the frame register, clear the index to 0, and go to WRITE. No timeout.
- WRITE: one register per cycle, index 0 to NUM_REGS-1 ascending.
  - regNum = index.
  - regData = frame[REG_WIDTH*index +: REG_WIDTH].
  - regWrite = ~SKIP_MASK[index].
  - regNum/regData are driven even when skipped. Implementation may zero regData on skip; the bench must not check it.
  - After index NUM_REGS-1, go to DONE. The index does not wrap inside WRITE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Fixed latency with restoreOut already high in WAIT: start at cycle 0; REQ at 1; WAIT at 2; first write at 3; last write at 18; done at 19.
- start while not in IDLE is ignored, with no queuing. start in the DONE cycle is also ignored.
- regWrite is 0 in every state except WRITE.
- frameIn changes after latch do not affect write-back data.
- fcc is sampled only in IDLE on start.

Decomposition:
- Shared package holds:
  - state encodings (IDLE..DONE, 3 bits);
  - constants NUM_REGS and REG_WIDTH, shared with the backup stack;
  - FRAME_W = NUM_REGS*REG_WIDTH.
- One sub-module, fbs_frame_unloader:
  - loadable frame register plus index counter;
  - outputs the current slice, the index, and a last flag;
  - the FSM stays in fbs_restore_ctrl.

Test Plan:
- Start with fcc=3, restoreOut=1, frameIn = register i holding 16'hA000+i, SKIP_MASK=0:
  - fbsRestore pulses at cycle 1;
  - regWrite high cycles 3-18 with regNum 0..15 and regData 16'hA000..16'hA00F;
  - done at cycle 19, busy high cycles 1-18.
- Start with fcc=0 -> underflow one-cycle pulse; fbsRestore, busy and regWrite stay 0.
- restoreOut held low 5 cycles after REQ -> stays in WAIT with busy=1 and no writes; first write the cycle after restoreOut rises.
- SKIP_MASK=16'h0001, same frame -> regWrite=0 at index 0, high for 1..15; done still at cycle 19.
- start pulsed again at cycle 8 and again in the DONE cycle -> ignored: one fbsRestore pulse, exactly 16 write cycles.
- reset asserted at cycle 10 (index 7) -> regWrite, busy and fbsRestore go 0 immediately. A later start with fcc=2 performs a full clean sequence from index 0.

Source files
------------

// File: rtl/fbs_restore_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fbs_restore_ctrl_pkg
// Brief    : Shared constants and FSM encoding for the f-register restore path.
// Revision : 1.0  initial release
// ============================================================================
package fbs_restore_ctrl_pkg;

   localparam int NUM_REGS  = 16;
   localparam int REG_WIDTH = 16;
   localparam int FRAME_W   = NUM_REGS * REG_WIDTH;
   localparam int IDX_W     = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fbs_restore_ctrl_frame_unloader.sv
`default_nettype none
// ============================================================================
// Module   : fbs_frame_unloader
// Brief    : Captured restore frame plus ascending register index.
// Revision : 1.0  initial release
// ============================================================================
module fbs_frame_unloader
   import fbs_restore_ctrl_pkg::*;
#(
   parameter int FRAME_REGS = NUM_REGS,
   parameter int SLICE_W    = REG_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_i,
   input  logic                          advance_i,
   input  logic [FRAME_REGS*SLICE_W-1:0] frame_i,
   output logic [SLICE_W-1:0]            slice_o,
   output logic [IDX_W-1:0]              idx_o,
   output logic                          last_o
);

   logic [FRAME_REGS*SLICE_W-1:0] frame_q, frame_d;
   logic [IDX_W-1:0]              idx_q, idx_d;

   // Index saturates at the last register so it never wraps mid-frame.
   always_comb begin
      frame_d = frame_q;
      idx_d   = idx_q;
      if (load_i) begin
         frame_d = frame_i;
         idx_d   = '0;
      end else if (advance_i && !last_o) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
         idx_q   <= '0;
      end else begin
         frame_q <= frame_d;
         idx_q   <= idx_d;
      end
   end

   assign slice_o = frame_q[idx_q*SLICE_W +: SLICE_W];
   assign idx_o   = idx_q;
   assign last_o  = (idx_q == IDX_W'(FRAME_REGS - 1));

endmodule
`default_nettype wire

// File: rtl/fbs_restore_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fbs_restore_ctrl
// Brief    : Requests a frame from the backup stack and writes it back to the
//            f-register file one register per cycle while stalling the pipe.
// Revision : 1.0  initial release
// ============================================================================
module fbs_restore_ctrl #(
   parameter int                  NUM_REGS  = fbs_restore_ctrl_pkg::NUM_REGS,
   parameter int                  REG_WIDTH = fbs_restore_ctrl_pkg::REG_WIDTH,
   parameter logic [NUM_REGS-1:0] SKIP_MASK = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [15:0]                   fcc,
   input  logic                          restoreOut,
   input  logic [NUM_REGS*REG_WIDTH-1:0] frameIn,
   output logic                          fbsRestore,
   output logic                          regWrite,
   output logic [3:0]                    regNum,
   output logic [REG_WIDTH-1:0]          regData,
   output logic                          busy,
   output logic                          done,
   output logic                          underflow
);

   import fbs_restore_ctrl_pkg::state_t;
   import fbs_restore_ctrl_pkg::ST_IDLE;
   import fbs_restore_ctrl_pkg::ST_REQ;
   import fbs_restore_ctrl_pkg::ST_WAIT;
   import fbs_restore_ctrl_pkg::ST_WRITE;
   import fbs_restore_ctrl_pkg::ST_DONE;

   state_t               state_q, state_d;
   logic                 load, advance, last;
   logic [3:0]           idx;
   logic [REG_WIDTH-1:0] slice;

   fbs_frame_unloader #(
      .FRAME_REGS (NUM_REGS),
      .SLICE_W    (REG_WIDTH)
   ) u_unloader (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load),
      .advance_i (advance),
      .frame_i   (frameIn),
      .slice_o   (slice),
      .idx_o     (idx),
      .last_o    (last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Outputs decode from the registered state so reset clears them at once.
   always_comb begin
      state_d    = state_q;
      fbsRestore = 1'b0;
      regWrite   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      underflow  = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (fcc != 16'd0) state_d   = ST_REQ;
               else              underflow = 1'b1;
            end
         end
         ST_REQ: begin
            busy       = 1'b1;
            fbsRestore = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (restoreOut) begin
               load    = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            busy     = 1'b1;
            regWrite = ~SKIP_MASK[idx];
            if (last) state_d = ST_DONE;
            else      advance = 1'b1;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign regNum  = idx;
   assign regData = slice;

endmodule
`default_nettype wire

// File: tb/tb_fbs_restore_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fbs_restore_ctrl
// Brief    : Scoreboard bench for fbs_restore_ctrl, with and without a skip mask.
// Revision : 1.0  initial release
// ============================================================================
module tb_fbs_restore_ctrl;
   import fbs_restore_ctrl_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset, start, restoreOut;
   logic [15:0]          fcc;
   logic [FRAME_W-1:0]   frameIn;
   logic                 fbs_a, wr_a, busy_a, done_a, uf_a;
   logic                 fbs_b, wr_b, busy_b, done_b, uf_b;
   logic [3:0]           num_a, num_b;
   logic [REG_WIDTH-1:0] data_a, data_b;

   always #5 clk = ~clk;

   fbs_restore_ctrl #(.SKIP_MASK(16'h0000)) dut_a (
      .clk(clk), .reset(reset), .start(start), .fcc(fcc), .restoreOut(restoreOut),
      .frameIn(frameIn), .fbsRestore(fbs_a), .regWrite(wr_a), .regNum(num_a),
      .regData(data_a), .busy(busy_a), .done(done_a), .underflow(uf_a));

   fbs_restore_ctrl #(.SKIP_MASK(16'h0001)) dut_b (
      .clk(clk), .reset(reset), .start(start), .fcc(fcc), .restoreOut(restoreOut),
      .frameIn(frameIn), .fbsRestore(fbs_b), .regWrite(wr_b), .regNum(num_b),
      .regData(data_b), .busy(busy_b), .done(done_b), .underflow(uf_b));

   typedef struct packed {
      logic [3:0]           num;
      logic [REG_WIDTH-1:0] data;
   } wr_t;

   wr_t q_a[$];
   wr_t q_b[$];
   wr_t e_a, e_b;
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic logic [FRAME_W-1:0] mkframe(input logic [15:0] base);
      logic [FRAME_W-1:0] f;
      f = '0;
      for (int i = 0; i < NUM_REGS; i++) f[i*REG_WIDTH +: REG_WIDTH] = base + 16'(i);
      return f;
   endfunction

   // Write-port monitor: every observed write must match the next expected one.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_a) begin
            if (q_a.size() == 0) chk("wr_a_unexpected", 32'd1, 32'd0);
            else begin
               e_a = q_a.pop_front();
               chk("wr_a_num", 32'(num_a), 32'(e_a.num));
               chk("wr_a_data", 32'(data_a), 32'(e_a.data));
            end
         end
         if (wr_b) begin
            if (q_b.size() == 0) chk("wr_b_unexpected", 32'd1, 32'd0);
            else begin
               e_b = q_b.pop_front();
               chk("wr_b_num", 32'(num_b), 32'(e_b.num));
               chk("wr_b_data", 32'(data_b), 32'(e_b.data));
            end
         end
      end
   end

   // One restore attempt. Entered and left just after a rising edge.
   // rr: first cycle restoreOut is high; r1/r2: extra start pulses; rst_at: async reset cycle.
   task automatic run(input string nm, input logic [15:0] fcc_v, input logic [FRAME_W-1:0] frm,
                      input int rr, input int r1, input int r2, input int ncyc, input int rst_at);
      bit acc;
      int w0;
      int bad_fbs, bad_busy, bad_done, bad_wa, bad_wb, bad_uf;
      bit ew;
      acc = (fcc_v != 16'd0);
      w0  = (rr <= 2) ? 3 : rr + 1;
      bad_fbs = 0; bad_busy = 0; bad_done = 0; bad_wa = 0; bad_wb = 0; bad_uf = 0;
      if (acc) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            q_a.push_back('{num: i[3:0], data: frm[i*REG_WIDTH +: REG_WIDTH]});
            if (i != 0) q_b.push_back('{num: i[3:0], data: frm[i*REG_WIDTH +: REG_WIDTH]});
         end
      end
      fcc     = fcc_v;
      frameIn = frm;
      for (int k = 0; k < ncyc; k++) begin
         start      = (k == 0 || k == r1 || k == r2);
         restoreOut = (k >= rr);
         if (k == w0 + 2) frameIn = ~frm;
         if (k == rst_at) begin
            chk({nm, "_pre_wr"}, 32'(wr_a), 32'd1);
            chk({nm, "_pre_idx"}, 32'(num_a), 32'd7);
            reset = 1'b1;
            #1;
            chk({nm, "_wr_a"}, 32'(wr_a), 32'd0);
            chk({nm, "_wr_b"}, 32'(wr_b), 32'd0);
            chk({nm, "_busy"}, 32'(busy_a), 32'd0);
            chk({nm, "_fbs"}, 32'(fbs_a), 32'd0);
            chk({nm, "_idx"}, 32'(num_a), 32'd0);
            break;
         end
         @(negedge clk);
         ew = acc && k >= w0 && k <= w0 + 15;
         bad_fbs  += int'(fbs_a  !== (acc && k == 1)) + int'(fbs_b !== (acc && k == 1));
         bad_busy += int'(busy_a !== (acc && k >= 1 && k <= w0 + 15))
                   + int'(busy_b !== (acc && k >= 1 && k <= w0 + 15));
         bad_done += int'(done_a !== (acc && k == w0 + 16)) + int'(done_b !== (acc && k == w0 + 16));
         bad_wa   += int'(wr_a !== ew);
         bad_wb   += int'(wr_b !== (ew && k != w0));
         bad_uf   += int'(uf_a !== (!acc && k == 0)) + int'(uf_b !== (!acc && k == 0));
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      if (rst_at < 0) begin
         chk({nm, "_fbs_pattern"}, 32'(bad_fbs), 32'd0);
         chk({nm, "_busy_pattern"}, 32'(bad_busy), 32'd0);
         chk({nm, "_done_pattern"}, 32'(bad_done), 32'd0);
         chk({nm, "_wr_a_pattern"}, 32'(bad_wa), 32'd0);
         chk({nm, "_wr_b_pattern"}, 32'(bad_wb), 32'd0);
         chk({nm, "_uf_pattern"}, 32'(bad_uf), 32'd0);
         chk({nm, "_q_a_drained"}, 32'(q_a.size()), 32'd0);
         chk({nm, "_q_b_drained"}, 32'(q_b.size()), 32'd0);
      end
   endtask

   logic [FRAME_W-1:0] rnd;

   initial begin
      reset = 1'b1; start = 1'b0; restoreOut = 1'b0; fcc = 16'd0; frameIn = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_fbs", 32'(fbs_a), 32'd0);
      chk("rst_wr", 32'(wr_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_uf", 32'(uf_a), 32'd0);
      chk("rst_num", 32'(num_a), 32'd0);
      chk("rst_data", 32'(data_a), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      run("basic", 16'd3, mkframe(16'hA000), 0, -1, -1, 23, -1);
      run("uflow", 16'd0, mkframe(16'hA000), 0, -1, -1, 5, -1);

      rnd = '0;
      for (int i = 0; i < NUM_REGS; i++) rnd[i*REG_WIDTH +: REG_WIDTH] = 16'($urandom);
      run("wait", 16'd1, rnd, 7, -1, -1, 28, -1);

      run("restart", 16'd3, mkframe(16'hA000), 0, 8, 19, 24, -1);

      run("midrst", 16'd3, mkframe(16'hC000), 0, -1, -1, 30, 10);
      chk("midrst_q_a_left", 32'(q_a.size()), 32'd9);
      chk("midrst_q_b_left", 32'(q_b.size()), 32'd9);
      q_a.delete();
      q_b.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy_a), 32'd0);
      @(posedge clk);
      #1;
      run("post", 16'd2, mkframe(16'h5A00), 0, -1, -1, 23, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got no finish expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
